// File: rtl/pcr_startup_init.sv
// -----------------------------------------------------------------------------
// pcr_startup_init
//
// Purpose:
//   Writes the startup values into the PCR bank when the management op enters
//   STARTUP_STATE. The value written depends on startup_type. When every
//   targeted PCR has been written, it raises pcr_startup_done, which the
//   startup completion checker ANDs with the done flags of the other
//   submodules. This block drives the PCR write port only while in
//   STARTUP_STATE.
//
//   startup_type handling:
//     1 TPM_RESET    every PCR is written
//     2 TPM_RESTART  every PCR is written
//     3 TPM_RESUME   only PCRs whose PRESERVE_MASK bit is 0 are written
//     other values   illegal; the block raises pcr_startup_err
//   A PCR whose ONES_MASK bit is set is written with all-ones. Every other
//   PCR is written with all-zeros.
//
// Ports:
//   clock             in   1         system clock
//   reset             in   1         synchronous reset, active-high
//   op_state          in   3         management op state (STARTUP_STATE = 3'b010)
//   startup_type      in   3         startup type, latched on entry
//   pcr_wr_en         out  1         write request to the PCR bank
//   pcr_wr_addr       out  ADDR_W    PCR index being written
//   pcr_wr_data       out  DIGEST_W  value being written
//   pcr_wr_ready      in   1         PCR bank accepts the write this cycle
//   pcr_startup_busy  out  1         clear sequence in progress
//   pcr_startup_done  out  1         PCR startup complete (level)
//   pcr_startup_err   out  1         illegal startup_type or stall timeout (level)
//
// Configuration macro:
//   PCR_STARTUP_TIMEOUT_EN  When defined, the block aborts to the error state
//                           after TIMEOUT_CYCLES consecutive cycles in which a
//                           write is requested but not accepted. When not
//                           defined, the block waits on pcr_wr_ready
//                           indefinitely.
// -----------------------------------------------------------------------------
module pcr_startup_init #(
    parameter int unsigned          PCR_COUNT      = 24,
    parameter int unsigned          ADDR_W         = 5,
    parameter int unsigned          DIGEST_W       = 256,
    parameter logic [PCR_COUNT-1:0] ONES_MASK      = 24'h7E0000,
    parameter logic [PCR_COUNT-1:0] PRESERVE_MASK  = 24'h00FFFF,
    parameter int unsigned          TIMEOUT_CYCLES = 1024
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [2:0]          op_state,
    input  logic [2:0]          startup_type,
    output logic                pcr_wr_en,
    output logic [ADDR_W-1:0]   pcr_wr_addr,
    output logic [DIGEST_W-1:0] pcr_wr_data,
    input  logic                pcr_wr_ready,
    output logic                pcr_startup_busy,
    output logic                pcr_startup_done,
    output logic                pcr_startup_err
);

    localparam logic [2:0]        STARTUP_STATE = 3'b010;
    localparam logic [2:0]        TYPE_RESET    = 3'd1;
    localparam logic [2:0]        TYPE_RESTART  = 3'd2;
    localparam logic [2:0]        TYPE_RESUME   = 3'd3;
    localparam logic [ADDR_W-1:0] LAST_IDX      = ADDR_W'(PCR_COUNT - 1);

    // Reject parameter sets that cannot work at elaboration time.
    if ((2 ** ADDR_W) < PCR_COUNT || TIMEOUT_CYCLES == 0) begin : g_bad_params
        $error("pcr_startup_init: ADDR_W too narrow for PCR_COUNT or TIMEOUT_CYCLES is zero");
    end

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        DONE,
        ERR
    } state_t;

    state_t                state_q, state_n;
    logic [ADDR_W-1:0]     idx_q, idx_n;
    logic [2:0]            type_q, type_n;
    logic                  wr_en_q, wr_en_n;
    logic [ADDR_W-1:0]     addr_q, addr_n;
    logic [DIGEST_W-1:0]   data_q, data_n;
    logic                  busy_q, busy_n;
    logic                  done_q, done_n;
    logic                  err_q, err_n;

    logic in_startup;
    logic type_legal;
    logic advance;
    logic last_idx;
    logic timeout_hit;

    // Returns 1 if the PCR at index i is written for the given startup type.
    function automatic logic is_target(input logic [2:0] kind, input logic [ADDR_W-1:0] i);
        return (kind == TYPE_RESUME) ? !PRESERVE_MASK[i] : 1'b1;
    endfunction

    // Returns the startup value for the PCR at index i.
    function automatic logic [DIGEST_W-1:0] init_value(input logic [ADDR_W-1:0] i);
        return {DIGEST_W{ONES_MASK[i]}};
    endfunction

    assign in_startup = (op_state == STARTUP_STATE);
    assign type_legal = (startup_type == TYPE_RESET) || (startup_type == TYPE_RESTART) ||
                        (startup_type == TYPE_RESUME);
    // In CLEAR, wr_en_q always equals is_target(idx). So the index advances
    // after one cycle for a PCR that is skipped, and only after the bank
    // accepts the write for a PCR that is targeted.
    assign advance    = !wr_en_q || pcr_wr_ready;
    assign last_idx   = (idx_q == LAST_IDX);

`ifdef PCR_STARTUP_TIMEOUT_EN
    localparam int unsigned STALL_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [STALL_W-1:0] stall_q, stall_n;
    logic               stalled;

    assign stalled     = (state_q == CLEAR) && wr_en_q && !pcr_wr_ready;
    // Fires on the edge that samples the TIMEOUT_CYCLES-th consecutive stall.
    assign timeout_hit = stalled && (stall_q == STALL_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        stall_n = '0;
        if (stalled && !timeout_hit) begin
            stall_n = stall_q + STALL_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_n;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // State register. The registered outputs are also updated here.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            type_q  <= '0;
            wr_en_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_n;
            idx_q   <= idx_n;
            type_q  <= type_n;
            wr_en_q <= wr_en_n;
            addr_q  <= addr_n;
            data_q  <= data_n;
            busy_q  <= busy_n;
            done_q  <= done_n;
            err_q   <= err_n;
        end
    end

    // Next-state logic.
    always_comb begin
        state_n = state_q;
        case (state_q)
            IDLE: begin
                if (in_startup) begin
                    state_n = type_legal ? CLEAR : ERR;
                end
            end
            CLEAR: begin
                if (!in_startup) begin
                    state_n = IDLE;
                end else if (timeout_hit) begin
                    state_n = ERR;
                end else if (advance && last_idx) begin
                    state_n = DONE;
                end
            end
            DONE, ERR: begin
                if (!in_startup) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Next values of the registered outputs and the datapath.
    always_comb begin
        idx_n   = idx_q;
        type_n  = type_q;
        wr_en_n = wr_en_q;
        addr_n  = addr_q;
        data_n  = data_q;
        busy_n  = busy_q;
        done_n  = done_q;
        err_n   = err_q;
        case (state_q)
            IDLE: begin
                if (in_startup) begin
                    type_n = startup_type;
                    if (type_legal) begin
                        idx_n   = '0;
                        busy_n  = 1'b1;
                        wr_en_n = is_target(startup_type, '0);
                        addr_n  = '0;
                        data_n  = init_value('0);
                    end else begin
                        err_n = 1'b1;
                    end
                end
            end
            CLEAR: begin
                if (!in_startup) begin
                    // An unacknowledged write is dropped on abort.
                    wr_en_n = 1'b0;
                    busy_n  = 1'b0;
                    done_n  = 1'b0;
                    err_n   = 1'b0;
                end else if (timeout_hit) begin
                    wr_en_n = 1'b0;
                    busy_n  = 1'b0;
                    err_n   = 1'b1;
                end else if (advance) begin
                    if (last_idx) begin
                        wr_en_n = 1'b0;
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                    end else begin
                        idx_n   = idx_q + ADDR_W'(1);
                        wr_en_n = is_target(type_q, idx_q + ADDR_W'(1));
                        addr_n  = idx_q + ADDR_W'(1);
                        data_n  = init_value(idx_q + ADDR_W'(1));
                    end
                end
            end
            DONE, ERR: begin
                if (!in_startup) begin
                    wr_en_n = 1'b0;
                    busy_n  = 1'b0;
                    done_n  = 1'b0;
                    err_n   = 1'b0;
                end
            end
            default: ;
        endcase
    end

    assign pcr_wr_en        = wr_en_q;
    assign pcr_wr_addr      = addr_q;
    assign pcr_wr_data      = data_q;
    assign pcr_startup_busy = busy_q;
    assign pcr_startup_done = done_q;
    assign pcr_startup_err  = err_q;

endmodule

// File: tb/tb_pcr_startup_init.sv
// -----------------------------------------------------------------------------
// tb_pcr_startup_init
//
// Self-checking bench for pcr_startup_init. It combines three kinds of test:
//   - table-driven startup runs
//   - hand-written sequences for the abort, reset and stall corner cases
//   - randomized runs checked every cycle against a behavioural reference
//     model that walks the PCR index list
// -----------------------------------------------------------------------------
module tb_pcr_startup_init;

    localparam int unsigned N          = 24;
    localparam int unsigned AW         = 5;
    localparam int unsigned DW         = 256;
    localparam int unsigned TB_TIMEOUT = 8;
    localparam logic [23:0] ONES       = 24'h7E0000;
    localparam logic [23:0] PRES       = 24'h00FFFF;

    logic           clock = 1'b0;
    logic           reset;
    logic [2:0]     op_state;
    logic [2:0]     startup_type;
    logic           pcr_wr_ready;
    logic           pcr_wr_en;
    logic [AW-1:0]  pcr_wr_addr;
    logic [DW-1:0]  pcr_wr_data;
    logic           pcr_startup_busy;
    logic           pcr_startup_done;
    logic           pcr_startup_err;

    pcr_startup_init #(
        .PCR_COUNT      (N),
        .ADDR_W         (AW),
        .DIGEST_W       (DW),
        .ONES_MASK      (ONES),
        .PRESERVE_MASK  (PRES),
        .TIMEOUT_CYCLES (TB_TIMEOUT)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .op_state         (op_state),
        .startup_type     (startup_type),
        .pcr_wr_en        (pcr_wr_en),
        .pcr_wr_addr      (pcr_wr_addr),
        .pcr_wr_data      (pcr_wr_data),
        .pcr_wr_ready     (pcr_wr_ready),
        .pcr_startup_busy (pcr_startup_busy),
        .pcr_startup_done (pcr_startup_done),
        .pcr_startup_err  (pcr_startup_err)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;
    int edge_no = 0;

    // Reference model: a session either idles, walks the PCR index list,
    // or sits finished or errored until op_state leaves STARTUP.
    bit m_idle, m_run, m_done, m_err;
    int m_type, m_pos, m_stall;
    int exp_q[$];
    int got_q[$];

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at edge %0d: got %0h, want %0h", name, edge_no, act, exp);
        end
    endtask

    function automatic bit tgt(input int t, input int i);
        return (t == 3) ? !PRES[i] : 1'b1;
    endfunction

    function automatic void model_reset();
        m_idle = 1; m_run = 0; m_done = 0; m_err = 0;
        m_type = 0; m_pos = 0; m_stall = 0;
    endfunction

    function automatic void model_edge(input bit rst, input int op, input int typ, input bit rdy);
        bit w;
        if (rst) begin
            model_reset();
        end else if (!m_idle && op != 2) begin
            m_idle = 1; m_run = 0; m_done = 0; m_err = 0;
        end else if (m_idle) begin
            if (op == 2) begin
                m_idle = 0;
                m_type = typ;
                m_stall = 0;
                if (typ >= 1 && typ <= 3) begin
                    m_run = 1; m_pos = 0;
                end else begin
                    m_err = 1;
                end
            end
        end else if (m_run) begin
            w = tgt(m_type, m_pos);
            if (w && !rdy) begin
                m_stall++;
`ifdef PCR_STARTUP_TIMEOUT_EN
                if (m_stall >= TB_TIMEOUT) begin
                    m_run = 0; m_err = 1;
                end
`endif
            end else begin
                m_stall = 0;
                if (w) exp_q.push_back(m_pos);
                if (m_pos == N - 1) begin
                    m_run = 0; m_done = 1;
                end else begin
                    m_pos++;
                end
            end
        end
    endfunction

    task automatic check_outputs();
        bit ew;
        logic [255:0] ed;
        ew = m_run && tgt(m_type, m_pos);
        check("flags{wr_en,busy,done,err}",
              {pcr_wr_en, pcr_startup_busy, pcr_startup_done, pcr_startup_err},
              {ew, m_run, m_done, m_err});
        if (ew) begin
            ed = ONES[m_pos] ? {256{1'b1}} : '0;
            check("wr_addr", pcr_wr_addr, m_pos);
            check("wr_data", pcr_wr_data, ed);
        end
    endtask

    // One clock edge. Inputs are sampled just before the edge and outputs are
    // checked 1 time unit after it.
    task automatic step();
        logic pre_wr, pre_rdy, pre_rst;
        logic [AW-1:0] pre_addr;
        logic [2:0] pre_op, pre_typ;
        pre_wr = pcr_wr_en; pre_rdy = pcr_wr_ready; pre_rst = reset;
        pre_addr = pcr_wr_addr; pre_op = op_state; pre_typ = startup_type;
        @(posedge clock);
        model_edge(pre_rst, int'(pre_op), int'(pre_typ), pre_rdy);
        #1;
        edge_no++;
        if (pre_wr && pre_rdy && !pre_rst && pre_op == 3'd2) got_q.push_back(int'(pre_addr));
        check_outputs();
    endtask

    typedef struct {
        logic [2:0] typ;
        int         rmode;      // 0: ready high, 1: one low cycle per write
        int         n_writes;
        int         term_edge;  // edge after which done or err is first high
        bit         exp_err;
        int         first_addr; // -1 when there are no writes
    } vec_t;

    vec_t vecs[9];

    task automatic idle_cycles(input int n);
        op_state = 3'd0; pcr_wr_ready = 1'b1;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic run_vec(input vec_t v);
        int term;
        int last_stalled;
        idle_cycles(2);
        got_q.delete(); exp_q.delete();
        startup_type = v.typ; op_state = 3'd2;
        term = -1; last_stalled = -1;
        for (int e = 1; e <= 200; e++) begin
            if (v.rmode == 1 && pcr_wr_en && int'(pcr_wr_addr) != last_stalled) begin
                pcr_wr_ready = 1'b0; last_stalled = int'(pcr_wr_addr);
            end else begin
                pcr_wr_ready = 1'b1;
            end
            step();
            if (e == 1) startup_type = ~v.typ;   // must be ignored once latched
            if (pcr_startup_done || pcr_startup_err) begin
                term = e;
                break;
            end
        end
        check("term_edge", term, v.term_edge);
        check("err_level", pcr_startup_err, v.exp_err);
        check("write_count", got_q.size(), v.n_writes);
        check("write_seq_len", got_q.size(), exp_q.size());
        foreach (got_q[i]) if (i < exp_q.size()) check("write_seq", got_q[i], exp_q[i]);
        if (v.first_addr >= 0) check("first_addr", (got_q.size() > 0) ? got_q[0] : -1, v.first_addr);
        // Remaining in STARTUP_STATE must not restart the sequence.
        for (int i = 0; i < 5; i++) step();
        check("no_restart_writes", got_q.size(), v.n_writes);
        op_state = 3'd3;
        step();
        check("exit_clears", {pcr_wr_en, pcr_startup_busy, pcr_startup_done, pcr_startup_err}, 4'b0000);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, edge %0d", edge_no);
        $fatal(1);
    end

    initial begin
        vecs[0] = '{3'd1, 0, 24, 25, 1'b0, 0};
        vecs[1] = '{3'd3, 0, 8,  25, 1'b0, 16};
        vecs[2] = '{3'd2, 1, 24, 49, 1'b0, 0};
        vecs[3] = '{3'd5, 0, 0,  1,  1'b1, -1};
        vecs[4] = '{3'd0, 0, 0,  1,  1'b1, -1};
        vecs[5] = '{3'd7, 1, 0,  1,  1'b1, -1};
        vecs[6] = '{3'd3, 1, 8,  33, 1'b0, 16};
        vecs[7] = '{3'd1, 1, 24, 49, 1'b0, 0};
        vecs[8] = '{3'd6, 0, 0,  1,  1'b1, -1};

        model_reset();
        reset = 1'b1; op_state = 3'd2; startup_type = 3'd1; pcr_wr_ready = 1'b1;
        step(); step();   // reset dominates op_state
        check("reset_outputs",
              {pcr_wr_en, pcr_startup_busy, pcr_startup_done, pcr_startup_err, pcr_wr_addr},
              '0);
        check("reset_data", pcr_wr_data, '0);
        reset = 1'b0;

        foreach (vecs[i]) run_vec(vecs[i]);

        // Abort at idx 10, then re-enter STARTUP_STATE.
        idle_cycles(2);
        startup_type = 3'd1; op_state = 3'd2; pcr_wr_ready = 1'b1;
        for (int i = 0; i < 11; i++) step();
        check("abort_pre_addr", {pcr_wr_en, pcr_wr_addr}, {1'b1, 5'd10});
        op_state = 3'd0;
        step();
        check("abort_drop", {pcr_wr_en, pcr_startup_busy}, 2'b00);
        op_state = 3'd2;
        step();
        check("reentry_addr0", {pcr_wr_en, pcr_startup_busy, pcr_wr_addr}, {2'b11, 5'd0});

        // Reset in the middle of CLEAR.
        for (int i = 0; i < 5; i++) step();
        reset = 1'b1;
        step();
        check("reset_mid_clear",
              {pcr_wr_en, pcr_startup_busy, pcr_startup_done, pcr_startup_err, pcr_wr_addr},
              '0);
        reset = 1'b0;

        // The bank never becomes ready.
        idle_cycles(2);
        startup_type = 3'd1; pcr_wr_ready = 1'b0; op_state = 3'd2;
        step();
        check("stall_first_wr", pcr_wr_en, 1'b1);
`ifdef PCR_STARTUP_TIMEOUT_EN
        for (int e = 2; e <= 8; e++) step();
        check("stall_err_not_yet", pcr_startup_err, 1'b0);
        step();
        check("stall_timeout_err", {pcr_startup_err, pcr_startup_done, pcr_wr_en}, 3'b100);
`else
        for (int e = 0; e < 2000; e++) step();
        check("stall_hold", {pcr_wr_en, pcr_startup_err, pcr_wr_addr}, {2'b10, 5'd0});
`endif
        op_state = 3'd0; pcr_wr_ready = 1'b1;
        step();

        // Randomized sessions checked against the model every cycle.
        for (int r = 0; r < 40; r++) begin
            idle_cycles(1 + $urandom_range(0, 1));
            startup_type = 3'($urandom_range(0, 7));
            op_state = 3'd2;
            for (int c = 0; c < 80; c++) begin
                pcr_wr_ready = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 59) == 0) op_state = 3'($urandom_range(0, 7));
                reset = ($urandom_range(0, 149) == 0);
                step();
                reset = 1'b0;
                if ($urandom_range(0, 3) == 0) startup_type = 3'($urandom_range(0, 7));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
